// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I control path: opcodes, ALU
// operation codes (also used by the ALU) and FSM state encoding.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-operation decoder and legality check.
// In: opcode, funct3, funct7_5 (instr[30]). Out: alu_ctrl, legal.
module alu_ctrl_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_ctrl,
   output logic       legal
);

   logic is_r;
   assign is_r = (opcode == OP_R);

   always_comb begin
      alu_ctrl = ALU_ADD;
      legal    = 1'b0;
      case (opcode)
         OP_R, OP_IMM: begin
            legal = 1'b1;
            case (funct3)
               3'b000: alu_ctrl = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b111: alu_ctrl = ALU_AND;
               3'b110: alu_ctrl = ALU_OR;
               3'b100: alu_ctrl = ALU_XOR;
               3'b010: alu_ctrl = ALU_SLT;
               3'b001: begin
                  alu_ctrl = ALU_SLL;
                  legal    = !funct7_5;
               end
               3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
               default: legal = 1'b0;
            endcase
            // R-type only gives instr[30] a meaning for SUB and SRA
            if (is_r && funct7_5 &&
                !(funct3 == 3'b000 || funct3 == 3'b101))
               legal = 1'b0;
         end
         OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
         OP_BRANCH: begin
            alu_ctrl = ALU_SUB;
            legal    = (funct3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM with memory handshake and timeout.
// In: clk, rst, instr, Zero, mem_ready. Out: datapath controls + status.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16,
   parameter int CNT_W        = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic [3:0]  ALUCtrl,
   output logic        loadPC,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        illegal_instr,
   output logic        mem_timeout,
   output logic        halted
);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             ill_q, to_q;
   logic             set_ill, set_to, cnt_clr, cnt_inc;
   logic [6:0]       opcode;
   logic [3:0]       dec_alu;
   logic             dec_legal;
   logic             is_load, is_store, is_branch, use_imm;
   logic             cnt_last;
   logic             unused_instr;

   assign opcode    = instr[6:0];
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign use_imm   = (opcode == OP_IMM) || is_load || is_store;
   assign cnt_last  = (cnt == CNT_W'(MEM_WAIT_MAX - 1));
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   alu_ctrl_decode u_dec (
      .opcode   (opcode),
      .funct3   (instr[14:12]),
      .funct7_5 (instr[30]),
      .alu_ctrl (dec_alu),
      .legal    (dec_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IF;
         cnt   <= '0;
         ill_q <= 1'b0;
         to_q  <= 1'b0;
      end else begin
         state <= state_next;
         if (cnt_clr)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + 1'b1;
         if (set_ill)
            ill_q <= 1'b1;
         if (set_to)
            to_q <= 1'b1;
      end
   end

   always_comb begin
      state_next    = state;
      set_ill       = 1'b0;
      set_to        = 1'b0;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;
      PCSrc         = 1'b0;
      ALUSrc        = 1'b0;
      RegWrite      = 1'b0;
      MemToReg      = 1'b0;
      ALUCtrl       = 4'b0000;
      loadPC        = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      illegal_instr = ill_q;
      mem_timeout   = to_q;
      halted        = 1'b0;
      unique case (state)
         S_IF: state_next = S_ID;
         S_ID: begin
            if (dec_legal) begin
               state_next = S_EX;
            end else begin
               state_next = S_HALT;
               set_ill    = 1'b1;
            end
         end
         S_EX: begin
            ALUSrc  = use_imm;
            ALUCtrl = dec_alu;
            if (!dec_legal) begin
               state_next = S_HALT;
               set_ill    = 1'b1;
            end else if (is_branch) begin
               loadPC     = 1'b1;
               PCSrc      = Zero;
               state_next = S_IF;
            end else if (is_load || is_store) begin
               cnt_clr    = 1'b1;
               state_next = S_MEM;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            ALUSrc   = use_imm;
            ALUCtrl  = dec_alu;
            MemRead  = is_load;
            MemWrite = is_store;
            // A response in the last allowed cycle beats the timeout
            if (mem_ready) begin
               if (is_load) begin
                  state_next = S_WB;
               end else begin
                  loadPC     = 1'b1;
                  state_next = S_IF;
               end
            end else if (cnt_last) begin
               set_to     = 1'b1;
               state_next = S_HALT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_WB: begin
            // ALU inputs kept stable so an R/I result is still valid
            ALUSrc     = use_imm;
            ALUCtrl    = dec_alu;
            RegWrite   = 1'b1;
            loadPC     = 1'b1;
            MemToReg   = is_load;
            state_next = S_IF;
         end
         S_HALT: halted = 1'b1;
         default: state_next = S_HALT;
      endcase
      if (rst) begin
         state_next    = S_IF;
         PCSrc         = 1'b0;
         ALUSrc        = 1'b0;
         RegWrite      = 1'b0;
         MemToReg      = 1'b0;
         ALUCtrl       = 4'b0000;
         loadPC        = 1'b0;
         MemRead       = 1'b0;
         MemWrite      = 1'b0;
         illegal_instr = 1'b0;
         mem_timeout   = 1'b0;
         halted        = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit driving the RV32I datapath's control inputs: `PCSrc`, `ALUSrc`, `RegWrite`, `MemToReg`, `ALUCtrl` and `loadPC`.
- Sits beside the datapath in the core top level and receives `instr` and `Zero` back from it.
- Sequences each instruction through a multicycle FSM and handles data-memory handshakes, with a wait timeout.
- Halts on an illegal opcode or a memory timeout.

Parameters:
- MEM_WAIT_MAX, 16: max cycles in MEM waiting for `mem_ready` before timeout; must be ≥1.
- CNT_W, 5: width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  current instruction; stable while PC is unchanged
- Zero  in  1  ALU zero flag from the datapath
- mem_ready  in  1  data memory has completed the current read/write
- PCSrc  out  1  select branch target for the next PC
- ALUSrc  out  1  ALU operand B: 0 = register, 1 = immediate
- RegWrite  out  1  register file write enable
- MemToReg  out  1  write-back source: 1 = memory, 0 = ALU
- ALUCtrl  out  4  ALU operation code
- loadPC  out  1  PC update strobe, one cycle
- MemRead  out  1  data memory read request
- MemWrite  out  1  data memory write request
- illegal_instr  out  1  sticky; unsupported opcode/funct seen
- mem_timeout  out  1  sticky; `mem_ready` not seen within MEM_WAIT_MAX
- halted  out  1  FSM is in HALT

Behaviour:
- Reset:
  - On a rising edge with `rst`=1, state←IF, wait counter←0, `illegal_instr`←0, `mem_timeout`←0.
  - While `rst`=1 every output is forced to 0.
  - `rst` mid-instruction aborts it; no pending strobe is emitted.
- States and transitions:
  - IF: one cycle, all outputs 0 → ID.
  - ID: decode opcode `instr[6:0]`.
    - Legal: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ (funct3=000) → EX.
    - Anything else (including unsupported funct3/funct7 combinations) → HALT, setting `illegal_instr`.
  - EX: `ALUSrc`=1 for I-ALU/LW/SW, 0 for R/BEQ; `ALUCtrl` from the decode rules below.
    - BEQ: `ALUCtrl`=SUB, `loadPC`=1, `PCSrc`=`Zero` → IF. Latency 3 cycles.
    - R/I-ALU → WB. LW/SW → MEM, wait counter cleared.
  - MEM: `MemRead` (LW) or `MemWrite` (SW) held high; `ALUSrc`/`ALUCtrl` held at their EX values.
    - `mem_ready`=1 in a MEM cycle: LW → WB; SW asserts `loadPC`=1 that same cycle → IF.
    - Otherwise the counter increments.
    - If the counter reaches MEM_WAIT_MAX-1 with `mem_ready`=0: → HALT, set `mem_timeout`, drop `MemRead`/`MemWrite` in the next cycle.
    - `mem_ready` in that same final cycle wins over the timeout.
  - WB: `RegWrite`=1, `loadPC`=1, `PCSrc`=0, `MemToReg`=1 for LW else 0 → IF.
  - Latencies: R/I-ALU 4 cycles; LW 5+waits; SW 4+waits.
  - HALT: all strobes 0, `halted`=1; only `rst` exits.
- Strobe rules:
  - `loadPC` is exactly one cycle per retired instruction, never in IF/ID/HALT.
  - `RegWrite` and `MemWrite` are never high together.
  - `mem_ready` outside MEM is ignored.
- ALUCtrl decode:
  - R-type: f3=000 → ADD, or SUB if `instr[30]`=1; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL, or SRA if `instr[30]`=1.
  - I-ALU: same table but f3=000 is always ADD; SRAI uses `instr[30]`.
  - LW/SW: ADD.
- Encoding:
  - Outputs are a registered state plus combinational decode of state, `instr` and `Zero`.
  - State is binary on 3 bits; unused codes → HALT.

Decomposition:
- Shared package `riscv_ctrl_pkg`:
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALUCtrl constants: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101. The ALU uses the same constants.
  - State encoding constants.
- One combinational sub-module, `alu_ctrl_decode` (opcode, funct3, funct7[5] → `ALUCtrl`, legal), reused by future pipelined control.

Test Plan:
- `rst` for 2 cycles, then `instr`=0x002081B3 (add x3,x1,x2) → IF,ID,EX,WB; EX `ALUCtrl`=0010, `ALUSrc`=0; WB `RegWrite`=1, `loadPC`=1, `MemToReg`=0; next `loadPC` 4 cycles after the first.
- `instr`=0x0080A283 (lw x5,8(x1)), `mem_ready` asserted on the 3rd MEM cycle → `MemRead` high 3 cycles, `ALUSrc`=1, `ALUCtrl`=0010; WB `MemToReg`=1, `RegWrite`=1; total 7 cycles.
- `instr`=0x00208463 (beq), `Zero`=1 then repeat with `Zero`=0 → EX `ALUCtrl`=0110, `loadPC`=1, `PCSrc`=1 then 0; 3 cycles each; `RegWrite` never high.
- `instr`=0x0050A623 (sw), `mem_ready` held 0 → `MemWrite` high exactly 16 cycles, then `halted`=1, `mem_timeout`=1, `loadPC` never pulses; `rst` clears all flags.
- `instr`=0xFFFFFFFF → HALT after ID, `illegal_instr`=1, all strobes 0; also 0x402081B3 (sub) → EX `ALUCtrl`=0110.
- `rst` asserted during MEM of an lw → next cycle state IF, `MemRead`=0, no `RegWrite`/`loadPC` emitted.
